// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte image, writes it
// word by word into instruction memory, and releases the core only after the
// length and checksum checks pass.
module imem_loader #(
    parameter int unsigned DEPTH     = 2000,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             core_hold,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIDX_W = 2;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    // state and datapath registers
    state_t              r_state;
    logic [WORD_W-1:0]   r_len;
    logic [BIDX_W-1:0]   r_byte_idx;
    logic [CNT_W-1:0]    r_word_idx;
    logic [WORD_W-1:0]   r_asm;
    logic [BYTE_W-1:0]   r_csum;
    logic                r_in_ready;
    logic                r_wr_en;
    logic [WORD_W-1:0]   r_wr_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic                r_core_hold;
    logic                r_done;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic [CNT_W-1:0]    r_words;

    // next-state values
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   w_len_nxt;
    logic [BIDX_W-1:0]   w_byte_idx_nxt;
    logic [CNT_W-1:0]    w_word_idx_nxt;
    logic [WORD_W-1:0]   w_asm_nxt;
    logic [BYTE_W-1:0]   w_csum_nxt;
    logic                w_in_ready_nxt;
    logic                w_wr_en_nxt;
    logic [WORD_W-1:0]   w_wr_addr_nxt;
    logic [WORD_W-1:0]   w_wr_data_nxt;
    logic                w_core_hold_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic [1:0]          w_err_code_nxt;
    logic [CNT_W-1:0]    w_words_nxt;

    // helper wires
    logic                w_accept;
    logic                w_last_byte;
    logic [WORD_W-1:0]   w_len_full;
    logic [WORD_W-1:0]   w_asm_full;
    logic [CNT_W-1:0]    w_word_inc;
    logic [WORD_W-1:0]   w_word_addr;
    logic                w_restart;

    // byte handshake and little-endian assembly of the incoming byte
    assign w_accept    = in_valid & r_in_ready;
    assign w_last_byte = (r_byte_idx == BIDX_W'(3));
    assign w_len_full  = {in_data, r_len[WORD_W-1:BYTE_W]};
    assign w_asm_full  = {in_data, r_asm[WORD_W-1:BYTE_W]};
    assign w_word_inc  = r_word_idx + CNT_W'(1);
    assign w_word_addr = BASE_ADDR + (WORD_W'(r_word_idx) << 2);
    assign w_restart   = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));

    // register outputs straight to ports
    assign in_ready     = r_in_ready;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign core_hold    = r_core_hold;
    assign done         = r_done;
    assign err          = r_err;
    assign err_code     = r_err_code;
    assign words_loaded = r_words;

    // next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_byte_idx_nxt = r_byte_idx;
        w_word_idx_nxt = r_word_idx;
        w_asm_nxt      = r_asm;
        w_csum_nxt     = r_csum;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;
        w_words_nxt    = r_words;

        if (w_restart) begin
            // a new load always starts from a clean slate
            w_state_nxt    = S_LEN;
            w_len_nxt      = '0;
            w_byte_idx_nxt = '0;
            w_word_idx_nxt = '0;
            w_asm_nxt      = '0;
            w_csum_nxt     = '0;
            w_done_nxt     = 1'b0;
            w_err_nxt      = 1'b0;
            w_err_code_nxt = ERR_NONE;
            w_words_nxt    = '0;
        end else begin
            case (r_state)
                S_LEN: begin
                    if (w_accept) begin
                        w_len_nxt      = w_len_full;
                        w_byte_idx_nxt = r_byte_idx + BIDX_W'(1);
                        if (w_last_byte) begin
                            if (w_len_full > WORD_W'(DEPTH)) begin
                                w_state_nxt    = S_ERR;
                                w_err_nxt      = 1'b1;
                                w_err_code_nxt = ERR_LEN;
                            end else if (w_len_full == '0) begin
                                w_state_nxt = S_CHECK;
                            end else begin
                                w_state_nxt = S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        w_asm_nxt      = w_asm_full;
                        w_csum_nxt     = r_csum ^ in_data;
                        w_byte_idx_nxt = r_byte_idx + BIDX_W'(1);
                        if (w_last_byte) begin
                            // word complete: strobe it out on the next cycle
                            w_wr_en_nxt    = 1'b1;
                            w_wr_data_nxt  = w_asm_full;
                            w_wr_addr_nxt  = w_word_addr;
                            w_words_nxt    = w_word_inc;
                            w_word_idx_nxt = w_word_inc;
                            if (WORD_W'(w_word_inc) == r_len) begin
                                w_state_nxt = S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (in_data == r_csum) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt    = S_ERR;
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_CSUM;
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERR: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_in_ready_nxt  = (w_state_nxt == S_LEN) | (w_state_nxt == S_DATA) |
                          (w_state_nxt == S_CHECK);
        w_core_hold_nxt = (w_state_nxt != S_DONE);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
            r_asm       <= '0;
            r_csum      <= '0;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= BASE_ADDR;
            r_wr_data   <= '0;
            r_core_hold <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_words     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_word_idx  <= w_word_idx_nxt;
            r_asm       <= w_asm_nxt;
            r_csum      <= w_csum_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_core_hold <= w_core_hold_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_err_code  <= w_err_code_nxt;
            r_words     <= w_words_nxt;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random images against a queue-based reference model.
module tb_imem_loader;

    localparam int unsigned DEPTH = 2000;
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             wr_en;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             core_hold;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] words_loaded;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_writes = 0;
    logic [31:0] last_addr = '0;

    logic [31:0] img[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_wl_q[$];

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .core_hold    (core_hold),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // every write strobe is matched against the next expected write
    always @(negedge clk) begin
        if (rst_n && wr_en === 1'b1) begin
            check("wr_pending", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) begin
                check("wr_addr", wr_addr, exp_addr_q.pop_front());
                check("wr_data", wr_data, exp_data_q.pop_front());
                check("wr_words", 32'(words_loaded), exp_wl_q.pop_front());
            end
            n_writes++;
            last_addr = wr_addr;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned budget;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        budget = 0;
        forever begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) begin
                @(posedge clk);
                break;
            end
            budget++;
            if (budget > 200) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // full load of img[0..n-1]; model derives writes and outcome from the stream rules
    task automatic run_load(input logic [31:0] n, input logic [7:0] cs_flip, input bit gaps);
        logic [7:0]  cs;
        logic [31:0] w;
        bit          len_bad;
        bit          ok;
        int unsigned wr_before;
        cs        = 8'h00;
        len_bad   = (n > DEPTH);
        ok        = !len_bad && (cs_flip == 8'h00);
        wr_before = n_writes;
        if (!len_bad) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_addr_q.push_back(BASE + 32'(i) * 4);
                exp_data_q.push_back(img[i]);
                exp_wl_q.push_back(32'(i + 1));
                w  = img[i];
                cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            end
        end
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gaps);
        if (!len_bad) begin
            for (int i = 0; i < int'(n); i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
            end
            send_byte(cs ^ cs_flip, gaps);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("done", 32'(done), 32'(ok));
        check("err", 32'(err), 32'(!ok));
        check("err_code", 32'(err_code), len_bad ? 32'd1 : (ok ? 32'd0 : 32'd2));
        check("core_hold", 32'(core_hold), 32'(!ok));
        check("words_loaded", 32'(words_loaded), len_bad ? 32'd0 : n);
        check("write_count", n_writes - wr_before, len_bad ? 32'd0 : n);
        check("wr_leftover", 32'(exp_addr_q.size()), 32'd0);
        check("in_ready_end", 32'(in_ready), 32'd0);
    endtask

    task automatic rand_img(input int unsigned n);
        img.delete();
        for (int i = 0; i < int'(n); i++) img.push_back($urandom);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset values and idle immunity to in_valid
        check("rst_core_hold", 32'(core_hold), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_wr_addr", wr_addr, BASE);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 32'd0);
            check("idle_core_hold", 32'(core_hold), 32'd1);
        end
        in_valid = 1'b0;
        check("idle_writes", n_writes, 32'd0);

        // directed two-word image, good then corrupted checksum
        img.delete();
        img.push_back(32'h00A0_0513);
        img.push_back(32'h0010_0593);
        run_load(32'd2, 8'h00, 1'b0);
        run_load(32'd2, 8'h01, 1'b0);

        // length DEPTH+1 rejected, then recovery with a single word
        run_load(32'd2001, 8'h00, 1'b0);
        rand_img(1);
        run_load(32'd1, 8'h00, 1'b0);

        // empty image: checksum of nothing is zero
        run_load(32'd0, 8'h00, 1'b0);
        run_load(32'd0, 8'h5A, 1'b1);

        // random small images with gaps and occasional bad checksums
        for (int t = 0; t < 6; t++) begin
            int unsigned n;
            n = $urandom_range(1, 12);
            rand_img(n);
            run_load(32'(n), ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, 1'b1);
        end

        // maximum size image
        rand_img(DEPTH);
        run_load(32'(DEPTH), 8'h00, 1'b1);
        check("max_last_addr", last_addr, BASE + 32'h0000_1F3C);

        // reset in the middle of DATA after three words
        rand_img(5);
        for (int i = 0; i < 3; i++) begin
            exp_addr_q.push_back(BASE + 32'(i) * 4);
            exp_data_q.push_back(img[i]);
            exp_wl_q.push_back(32'(i + 1));
        end
        pulse_start();
        begin
            logic [31:0] n5;
            logic [31:0] w;
            n5 = 32'd5;
            for (int k = 0; k < 4; k++) send_byte(n5[8*k +: 8], 1'b0);
            for (int i = 0; i < 3; i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
            end
            w = img[3];
            send_byte(w[7:0], 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_writes_done", 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_core_hold", 32'(core_hold), 32'd1);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_wr_addr", wr_addr, BASE);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rand_img(1);
        run_load(32'd1, 8'h00, 1'b0);
        check("post_rst_addr", last_addr, BASE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
